// File: rtl/if_pkg.sv
// -----------------------------------------------------------------------------
// if_pkg
// Shared definitions for the instruction fetch unit and its prefetch FIFO:
//   XLEN         - machine word / address width
//   INSTR_BYTES  - byte stride between consecutive instructions
//   NOP_INSTR    - canonical no-op encoding (addi x0, x0, 0)
//   state_e      - fetch control states
//   fetch_entry_t- one buffered fetch: instruction word plus its byte address
// -----------------------------------------------------------------------------
package if_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~XLEN'(INSTR_BYTES - 1);
  endfunction

  // Sequential successor of a fetch address; wraps at 2^XLEN.
  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/if_prefetch_fifo.sv
// -----------------------------------------------------------------------------
// if_prefetch_fifo
// DEPTH-entry FIFO of (instr, pc) pairs between the memory response port and
// decode. The head entry is read combinationally from storage.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset (pointers/count only)
//   push        - write push_entry at the tail
//   push_entry  - entry to write
//   pop         - drop the head entry
//   flush       - empty the FIFO; wins over push and pop
//   head        - current head entry (meaningful only when !empty)
//   count       - number of valid entries
//   full, empty - occupancy flags
// -----------------------------------------------------------------------------
module if_prefetch_fifo
  import if_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  fetch_entry_t       push_entry,
  input  logic               pop,
  input  logic               flush,
  output fetch_entry_t       head,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  // A push into a full FIFO is accepted only when the head leaves in the
  // same cycle; the slot being freed is the one the tail now occupies.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  assign head = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // Data storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
// Instruction fetch stage. Issues sequential word fetches to instruction
// memory over a req/gnt port, buffers the in-order responses in a prefetch
// FIFO and hands (instr, pc) to decode over a valid/ready handshake. A
// redirect flushes the FIFO and discards every fetch still in flight.
// Ports:
//   clk_i, rst_i          - clock, asynchronous active-high reset
//   start_i               - leave IDLE and begin fetching
//   imem_req_o/addr_o     - fetch request and word-aligned byte address
//   imem_gnt_i            - memory accepted the request this cycle
//   imem_rvalid_i/rdata_i - in-order response word
//   redirect_i/pc_i       - flush and restart fetch at redirect_pc_i
//   instr_valid_o/instr_o/instr_pc_o/instr_ready_i - decode handshake
// -----------------------------------------------------------------------------
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            instr_valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  input  logic            instr_ready_i
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  state_e           state_q, state_d;
  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] discard_q, discard_d;

  logic             grant;
  logic             rsp_run;
  logic             push;
  logic             pop;
  logic             credit_ok;
  logic [CNT_W:0]   inflight;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  fetch_entry_t     fifo_head;
  fetch_entry_t     push_entry;

  // Credit: every granted fetch reserves a FIFO slot until it is popped,
  // so buffered plus in-flight words can never exceed DEPTH.
  assign inflight  = {1'b0, fifo_count} + {1'b0, outstanding_q};
  assign credit_ok = (inflight < (CNT_W + 1)'(DEPTH));

  assign imem_req_o  = (state_q == RUN) && !redirect_i && credit_ok;
  assign imem_addr_o = fetch_pc_q;
  assign grant       = imem_req_o && imem_gnt_i;

  // Responses are only meaningful in RUN; anything arriving in IDLE
  // (e.g. stragglers from before a reset) is ignored outright.
  assign rsp_run = (state_q == RUN) && imem_rvalid_i;
  assign push    = rsp_run && (discard_q == '0) && !redirect_i;
  assign pop     = instr_valid_o && instr_ready_i;

  assign push_entry = '{instr: imem_rdata_i, pc: resp_pc_q};

  if_prefetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk_i),
    .rst        (rst_i),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect_i),
    .head       (fifo_head),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // Storage is unreset, so the data outputs are forced to zero while empty.
  assign instr_valid_o = !fifo_empty;
  assign instr_o       = fifo_empty ? '0 : fifo_head.instr;
  assign instr_pc_o    = fifo_empty ? '0 : fifo_head.pc;

  always_comb begin
    state_d = state_q;
    if ((state_q == IDLE) && start_i) state_d = RUN;
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    if (redirect_i) begin
      // Request is forced low, so no grant can coincide with a redirect.
      // Every fetch still in flight after this cycle belongs to the old
      // path and must be dropped when it returns. resp_pc is reloaded in
      // IDLE as well so the first response after start carries the right PC.
      fetch_pc_d    = align_pc(redirect_pc_i);
      resp_pc_d     = align_pc(redirect_pc_i);
      outstanding_d = outstanding_q - CNT_W'(rsp_run);
      discard_d     = outstanding_q - CNT_W'(rsp_run);
    end else begin
      if (grant) fetch_pc_d = next_pc(fetch_pc_q);
      outstanding_d = outstanding_q + CNT_W'(grant) - CNT_W'(rsp_run);
      if (rsp_run && (discard_q != '0)) discard_d = discard_q - CNT_W'(1);
      if (push) resp_pc_d = next_pc(resp_pc_q);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  // Protocol checks: a response needs a matching request, and the credit
  // rule must keep pushes from landing in a full FIFO without a pop.
  always @(posedge clk_i) begin
    if (!rst_i && (state_q == RUN) && imem_rvalid_i) begin
      assert (outstanding_q != '0)
        else $error("imem_rvalid_i with no outstanding fetch");
    end
    if (!rst_i && !redirect_i) begin
      assert (!(push && fifo_full && !pop))
        else $error("prefetch FIFO overflow");
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'h0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i = 1'b0;

  if_fetch_unit #(
    .DEPTH    (4),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Memory model contents: word at byte address a.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  // Environment knobs and scoreboard state.
  int          gnt_mode   = 0;  // 0 never, 1 always, 2 random
  int          ready_mode = 0;  // 0 never, 1 always, 2 random
  int          lat_min    = 1;
  int          lat_max    = 1;
  bit          resp_hold  = 1'b0;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          cyc        = 0;
  int          last_due   = 0;
  logic [31:0] exp_pc     = RESET_PC;
  logic [31:0] first_pop_pc = 32'hFFFF_FFFF;
  bit          got_first  = 1'b0;
  int          pops       = 0;
  int          grants     = 0;
  logic [31:0] grant_log[$];

  // First half of a cycle: drive inputs, then sample and score mid-cycle.
  task automatic tick_a(input bit redir, input logic [31:0] rpc, input bit st);
    int lat;
    int due;
    start_i       = st;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    imem_gnt_i    = (gnt_mode == 1) || ((gnt_mode == 2) && ($urandom_range(0, 1) == 1));
    instr_ready_i = (ready_mode == 1) || ((ready_mode == 2) && ($urandom_range(0, 1) == 1));
    if (!resp_hold && (pend_due.size() > 0) && (pend_due[0] <= cyc)) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_word(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
    end
    #3;
    if (imem_req_o && imem_gnt_i) begin
      lat = $urandom_range(lat_min, lat_max);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend_addr.push_back(imem_addr_o);
      pend_due.push_back(due);
      grant_log.push_back(imem_addr_o);
      grants++;
    end
    if (instr_valid_o && instr_ready_i) begin
      chk("pop_pc", instr_pc_o, exp_pc);
      chk("pop_instr", instr_o, mem_word(exp_pc));
      if (!got_first) begin
        got_first    = 1'b1;
        first_pop_pc = instr_pc_o;
      end
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
    if (redir) exp_pc = rpc & 32'hFFFF_FFFC;
  endtask

  task automatic tick_b();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic tick(input bit redir, input logic [31:0] rpc, input bit st);
    tick_a(redir, rpc, st);
    tick_b();
  endtask

  task automatic do_reset(input bit clear);
    rst_i         = 1'b1;
    start_i       = 1'b0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    redirect_i    = 1'b0;
    instr_ready_i = 1'b0;
    #1;
    chk("rst_req", {31'b0, imem_req_o}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid_o}, 32'd0);
    chk("rst_addr", imem_addr_o, RESET_PC);
    chk("rst_instr", instr_o, 32'd0);
    chk("rst_instr_pc", instr_pc_o, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    cyc += 2;
    exp_pc    = RESET_PC;
    got_first = 1'b0;
    first_pop_pc = 32'hFFFF_FFFF;
    pops   = 0;
    grants = 0;
    grant_log.delete();
    resp_hold = 1'b0;
    if (clear) begin
      pend_addr.delete();
      pend_due.delete();
      last_due = cyc;
    end
  endtask

  initial begin
    // Reset and idle behaviour.
    do_reset(1'b1);
    gnt_mode = 1; ready_mode = 1; lat_min = 1; lat_max = 1;
    tick_a(1'b0, 32'h0, 1'b0);
    chk("idle_no_req", {31'b0, imem_req_o}, 32'd0);
    tick_b();

    // Streaming: gnt every cycle, 1-cycle response, decode always ready.
    tick(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 20; i++) tick(1'b0, 32'h0, 1'b0);
    chk("stream_grant0", grant_log[0], 32'h0);
    chk("stream_grant1", grant_log[1], 32'h4);
    chk("stream_grant2", grant_log[2], 32'h8);
    chk("stream_grants", grants, 32'd20);
    chk("stream_pops", pops, 32'd18);

    // Backpressure: exactly DEPTH grants, then request drops.
    do_reset(1'b1);
    gnt_mode = 1; ready_mode = 0; lat_min = 1; lat_max = 1;
    tick(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 10; i++) tick(1'b0, 32'h0, 1'b0);
    chk("bp_grants", grants, 32'd4);
    chk("bp_grant3", grant_log[3], 32'hC);
    chk("bp_req_low", {31'b0, imem_req_o}, 32'd0);
    chk("bp_valid", {31'b0, instr_valid_o}, 32'd1);
    chk("bp_head_pc", instr_pc_o, 32'h0);
    chk("bp_head_instr", instr_o, mem_word(32'h0));
    ready_mode = 1;
    for (int i = 0; i < 10; i++) tick(1'b0, 32'h0, 1'b0);
    chk("bp_resume_addr", grant_log[4], 32'h10);
    chk("bp_drain_pops", pops, 32'd10);

    // Redirect with two fetches in flight; late responses must be dropped.
    do_reset(1'b1);
    gnt_mode = 1; ready_mode = 1; lat_min = 1; lat_max = 1;
    resp_hold = 1'b1;
    tick(1'b0, 32'h0, 1'b1);
    tick(1'b0, 32'h0, 1'b0);
    tick(1'b0, 32'h0, 1'b0);
    gnt_mode = 0;
    chk("rd_inflight", grants, 32'd2);
    tick_a(1'b1, 32'h103, 1'b0);
    chk("rd_req_low", {31'b0, imem_req_o}, 32'd0);
    tick_b();
    gnt_mode  = 1;
    resp_hold = 1'b0;
    tick_a(1'b0, 32'h0, 1'b0);
    chk("rd_req", {31'b0, imem_req_o}, 32'd1);
    chk("rd_addr", imem_addr_o, 32'h100);
    tick_b();
    for (int i = 0; i < 10; i++) tick(1'b0, 32'h0, 1'b0);
    chk("rd_got_first", {31'b0, got_first}, 32'd1);
    chk("rd_first_pc", first_pop_pc, 32'h100);

    // Redirect coinciding with an rvalid and a completing pop.
    do_reset(1'b1);
    gnt_mode = 1; ready_mode = 1; lat_min = 1; lat_max = 1;
    tick(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 6; i++) tick(1'b0, 32'h0, 1'b0);
    tick_a(1'b1, 32'h200, 1'b0);
    chk("rc_pop_valid", {31'b0, instr_valid_o}, 32'd1);
    chk("rc_rvalid", {31'b0, imem_rvalid_i}, 32'd1);
    tick_b();
    tick_a(1'b0, 32'h0, 1'b0);
    chk("rc_empty1", {31'b0, instr_valid_o}, 32'd0);
    chk("rc_req", {31'b0, imem_req_o}, 32'd1);
    chk("rc_addr", imem_addr_o, 32'h200);
    tick_b();
    tick_a(1'b0, 32'h0, 1'b0);
    chk("rc_empty2", {31'b0, instr_valid_o}, 32'd0);
    tick_b();
    tick_a(1'b0, 32'h0, 1'b0);
    chk("rc_valid3", {31'b0, instr_valid_o}, 32'd1);
    chk("rc_pc3", instr_pc_o, 32'h200);
    tick_b();
    for (int i = 0; i < 4; i++) tick(1'b0, 32'h0, 1'b0);

    // Random grant, latency 1-5, random ready, occasional redirects.
    do_reset(1'b1);
    gnt_mode = 2; ready_mode = 2; lat_min = 1; lat_max = 5;
    tick(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 3)
        tick(1'b1, {22'b0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))}, 1'b0);
      else
        tick(1'b0, 32'h0, 1'b0);
    end
    chk("rand_progress", {31'b0, (pops >= 50)}, 32'd1);

    // Reset with three fetches in flight; stragglers must be ignored.
    do_reset(1'b1);
    gnt_mode = 1; ready_mode = 0; lat_min = 1; lat_max = 1;
    resp_hold = 1'b1;
    tick(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b0, 32'h0, 1'b0);
    gnt_mode = 0;
    chk("mr_inflight", grants, 32'd3);
    do_reset(1'b0);
    ready_mode = 1;
    for (int i = 0; i < 6; i++) begin
      tick_a(1'b0, 32'h0, 1'b0);
      chk("mr_no_req", {31'b0, imem_req_o}, 32'd0);
      chk("mr_no_valid", {31'b0, instr_valid_o}, 32'd0);
      tick_b();
    end
    gnt_mode = 1;
    tick_a(1'b0, 32'h0, 1'b1);
    chk("mr_start_req", {31'b0, imem_req_o}, 32'd0);
    tick_b();
    tick_a(1'b0, 32'h0, 1'b0);
    chk("mr_req", {31'b0, imem_req_o}, 32'd1);
    chk("mr_addr", imem_addr_o, RESET_PC);
    tick_b();
    for (int i = 0; i < 6; i++) tick(1'b0, 32'h0, 1'b0);
    chk("mr_got_first", {31'b0, got_first}, 32'd1);
    chk("mr_first_pc", first_pop_pc, RESET_PC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
